// File: rtl/idt_cfg_shifter.sv
// idt_cfg_shifter: serial programmer for the IDT clock synthesizer's 24-bit
// configuration word ({c[1:0], ttl, f[1:0], s[2:0], v[8:0], r[6:0]}).
//
// Ports:
//   clk        config clock (osc_clk domain)
//   reset_     asynchronous active-low reset
//   cfg_start  one-cycle request to program cfg_word
//   cfg_word   word to send, latched only when a start is accepted
//   busy       high while a programming sequence runs
//   done       one-cycle pulse when a sequence completes
//   idt_sclk   serial clock to the IDT part
//   idt_data   serial data, bit 23 first
//   idt_strobe load strobe to the IDT part
//
// Optional macro IDT_AUTO_CFG_EN: when defined, a DEFAULT_CFG sequence starts
// on the first clk edge after reset release, with no cfg_start needed.
module idt_cfg_shifter #(
    parameter int unsigned  CLK_DIV       = 2,
    parameter int unsigned  STROBE_CYCLES = 4,
    parameter logic [23:0]  DEFAULT_CFG   = 24'h310126
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cfg_start,
    input  logic [23:0] cfg_word,
    output logic        busy,
    output logic        done,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOW    = 3'd1;
    localparam logic [2:0] HIGH   = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] STROBE = 3'd4;

    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
    localparam logic [7:0] STB_LD = 8'(STROBE_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    // Bit 23 goes straight to idt_data at start, so only 22..0 are held.
    logic [22:0] shift_reg;

    logic        go;
    logic [23:0] go_word;

`ifdef IDT_AUTO_CFG_EN
    // Set by reset, cleared on the first edge after release; that edge
    // launches the default sequence while the FSM is known to be IDLE.
    logic auto_pend;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign go      = auto_pend | cfg_start;
    assign go_word = auto_pend ? DEFAULT_CFG : cfg_word;
`else
    assign go      = cfg_start;
    assign go_word = cfg_word;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        shift_reg <= go_word[22:0];
                        bit_cnt   <= 5'd23;
                        busy      <= 1'b1;
                        idt_data  <= go_word[23];
                        idt_sclk  <= 1'b0;
                        cnt       <= DIV_LD;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == 8'd0) begin
                        idt_sclk <= 1'b1;
                        cnt      <= DIV_LD;
                        state    <= HIGH;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == 8'd0) begin
                        idt_sclk <= 1'b0;
                        cnt      <= DIV_LD;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt   <= bit_cnt - 5'd1;
                            idt_data  <= shift_reg[22];
                            shift_reg <= {shift_reg[21:0], 1'b0};
                            state     <= LOW;
                        end else begin
                            idt_data <= 1'b0;
                            state    <= GAP;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        idt_strobe <= 1'b1;
                        cnt        <= STB_LD;
                        state      <= STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        idt_strobe <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idt_cfg_shifter.sv
// tb_idt_cfg_shifter: randomized self-checking bench for idt_cfg_shifter.
// Two instances: CLK_DIV=2/STROBE=4 and CLK_DIV=1/STROBE=1.
module tb_idt_cfg_shifter;

    localparam int DV0 = 2;
    localparam int SV0 = 4;
    localparam int DV1 = 1;
    localparam int SV1 = 1;
    localparam logic [23:0] DEF = 24'h310126;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [1:0]  start = '0;
    logic [23:0] word [2];
    logic [1:0]  busy, done, sclk, data, stb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    idt_cfg_shifter #(.CLK_DIV(DV0), .STROBE_CYCLES(SV0), .DEFAULT_CFG(DEF)) u_d0 (
        .clk(clk), .reset_(reset_), .cfg_start(start[0]), .cfg_word(word[0]),
        .busy(busy[0]), .done(done[0]), .idt_sclk(sclk[0]),
        .idt_data(data[0]), .idt_strobe(stb[0])
    );

    idt_cfg_shifter #(.CLK_DIV(DV1), .STROBE_CYCLES(SV1), .DEFAULT_CFG(DEF)) u_d1 (
        .clk(clk), .reset_(reset_), .cfg_start(start[1]), .cfg_word(word[1]),
        .busy(busy[1]), .done(done[1]), .idt_sclk(sclk[1]),
        .idt_data(data[1]), .idt_strobe(stb[1])
    );

    function automatic int dv(input int i);
        return (i == 0) ? DV0 : DV1;
    endfunction

    function automatic int sv(input int i);
        return (i == 0) ? SV0 : SV1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observer: running totals per instance, sampled mid-cycle.
    int          cyc = 0;
    int          busy_n [2] = '{0, 0};
    int          rise_n [2] = '{0, 0};
    int          done_n [2] = '{0, 0};
    int          stb_n  [2] = '{0, 0};
    int          stb_dly[2] = '{0, 0};
    int          lfall  [2] = '{0, 0};
    int          lrise  [2] = '{0, 0};
    int          per_bad[2] = '{0, 0};
    int          dbad_n [2] = '{0, 0};
    logic [23:0] cap    [2];
    logic [1:0]  psclk = '0;
    logic [1:0]  pstb = '0;
    logic [1:0]  seen = '0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (busy[i]) busy_n[i]++;
            if (!busy[i]) seen[i] = 1'b0;
            if (sclk[i] && !psclk[i]) begin
                cap[i] = {cap[i][22:0], data[i]};
                rise_n[i]++;
                if (seen[i] && (cyc - lrise[i] != 2 * dv(i))) per_bad[i]++;
                seen[i] = 1'b1;
                lrise[i] = cyc;
            end
            if (!sclk[i] && psclk[i]) lfall[i] = cyc;
            if (stb[i] && !pstb[i]) stb_dly[i] = cyc - lfall[i];
            if (stb[i]) stb_n[i]++;
            if (done[i]) begin
                done_n[i]++;
                if (busy[i] || data[i] || sclk[i] || stb[i]) dbad_n[i]++;
            end
            psclk[i] = sclk[i];
            pstb[i]  = stb[i];
        end
    end

    // Program one word on instance i; optionally poke a competing start
    // (all ones) at cycle inj of the sequence, then idle for tail cycles.
    task automatic run_seq(input int i, input logic [23:0] w,
                           input int inj, input int tail);
        int b_busy, b_rise, b_done, b_stb, b_per, b_dbad, n;
        b_busy = busy_n[i];
        b_rise = rise_n[i];
        b_done = done_n[i];
        b_stb  = stb_n[i];
        b_per  = per_bad[i];
        b_dbad = dbad_n[i];
        @(negedge clk);
        word[i]  = w;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        word[i]  = 24'($urandom);
        n = 1;
        while (done_n[i] == b_done && n < LIMIT) begin
            @(posedge clk);
            n++;
            if (n == inj) begin
                @(negedge clk);
                start[i] = 1'b1;
                word[i]  = 24'hFFFFFF;
                @(negedge clk);
                start[i] = 1'b0;
            end
        end
        check("timeout", 32'(n < LIMIT), 32'd1);
        repeat (tail) @(negedge clk);
        check("busy_len", 32'(busy_n[i] - b_busy), 32'(49 * dv(i) + sv(i)));
        check("rises", 32'(rise_n[i] - b_rise), 32'd24);
        check("word", 32'(cap[i]), 32'(w));
        check("done_n", 32'(done_n[i] - b_done), 32'd1);
        check("stb_len", 32'(stb_n[i] - b_stb), 32'(sv(i)));
        check("stb_dly", 32'(stb_dly[i]), 32'(dv(i)));
        check("sclk_per", 32'(per_bad[i] - b_per), 32'd0);
        check("done_st", 32'(dbad_n[i] - b_dbad), 32'd0);
        if (tail > 0) check("idle", 32'(busy[i]), 32'd0);
    endtask

    task automatic after_reset();
`ifdef IDT_AUTO_CFG_EN
        int b0, b1, n;
        b0 = done_n[0];
        b1 = done_n[1];
        n = 0;
        while ((done_n[0] == b0 || done_n[1] == b1) && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        check("auto_to", 32'(n < LIMIT), 32'd1);
        repeat (10) @(negedge clk);
        check("auto_w0", 32'(cap[0]), 32'(DEF));
        check("auto_w1", 32'(cap[1]), 32'(DEF));
        check("auto_d0", 32'(done_n[0] - b0), 32'd1);
        check("auto_d1", 32'(done_n[1] - b1), 32'd1);
`else
        repeat (5) @(negedge clk);
        check("noauto", 32'({busy, done, sclk, data, stb}), 32'd0);
`endif
    endtask

    initial begin
        int b_done, b_stb, i;
        word[0] = '0;
        word[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'({busy, done, sclk, data, stb}), 32'd0);
        reset_ = 1'b1;
        after_reset();

        run_seq(0, 24'h310126, 0, 5);
        run_seq(0, 24'h310126, 30, 5);
        run_seq(0, 24'h000001, 0, 0);
        run_seq(0, 24'h800000, 0, 5);

        b_done = done_n[0];
        b_stb  = stb_n[0];
        @(negedge clk);
        word[0]  = 24'hC3C3C3;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (48) @(posedge clk);
        #2 reset_ = 1'b0;
        #1 check("rst_async", 32'({busy, done, sclk, data, stb}), 32'd0);
        repeat (4) @(negedge clk);
        check("rst_done", 32'(done_n[0] - b_done), 32'd0);
        check("rst_stb", 32'(stb_n[0] - b_stb), 32'd0);
        reset_ = 1'b1;
        after_reset();
        run_seq(0, 24'h5A5A5A, 0, 5);

        run_seq(1, 24'hA5C3E7, 0, 5);

        repeat (6) begin
            i = int'($urandom_range(0, 1));
            run_seq(i, 24'($urandom), int'($urandom_range(2, 60)),
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
